vga_sync_porch: RTL



---
 rtl/vga_timing_pkg.sv | 66 ++++++
 rtl/vga_sync_to_count.sv | 126 ++++++++++++
 rtl/vga_sync_porch.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// ----------------------------------------------------------------------------
// vga_timing_pkg
//
// Purpose : Shared 640x480 @ 25 MHz VGA timing constants. The upstream
//           sync/count generator and the sync/porch back end both import this
//           package so their notion of line and frame geometry cannot drift.
//
// Contents:
//   COUNT_WIDTH / count_t      - width and type of every position counter
//   *_COLS / *_ROWS            - total and visible geometry
//   H_/V_ porch and sync sizes - front porch, sync width, derived back porch
//   H_/V_SYNC_START/_END       - first position inside and first position
//                                after the sync pulse (half-open window)
//   in_window()                - half-open range test on a counter value
//   next_count()               - counter increment with wrap at a last value
// ----------------------------------------------------------------------------
package vga_timing_pkg;

    // Every position counter in the video path is this wide, which limits
    // the total line length and the total frame height to 1024.
    localparam int COUNT_WIDTH = 10;
    localparam int COUNT_LIMIT = 1 << COUNT_WIDTH;

    typedef logic [COUNT_WIDTH-1:0] count_t;

    // Geometry
    localparam int TOTAL_COLS    = 800;
    localparam int TOTAL_ROWS    = 525;
    localparam int ACTIVE_COLS   = 640;
    localparam int ACTIVE_ROWS   = 480;

    // Horizontal blanking breakdown
    localparam int H_FRONT_PORCH = 16;
    localparam int H_SYNC_WIDTH  = 96;
    localparam int H_SYNC_START  = ACTIVE_COLS + H_FRONT_PORCH;
    localparam int H_SYNC_END    = H_SYNC_START + H_SYNC_WIDTH;
    localparam int H_BACK_PORCH  = TOTAL_COLS - H_SYNC_END;

    // Vertical blanking breakdown
    localparam int V_FRONT_PORCH = 10;
    localparam int V_SYNC_WIDTH  = 2;
    localparam int V_SYNC_START  = ACTIVE_ROWS + V_FRONT_PORCH;
    localparam int V_SYNC_END    = V_SYNC_START + V_SYNC_WIDTH;
    localparam int V_BACK_PORCH  = TOTAL_ROWS - V_SYNC_END;

    // Colour depth per channel
    localparam int VIDEO_WIDTH   = 3;

    // True when first <= pos < last_excl.
    function automatic logic in_window(
        input count_t pos,
        input count_t first,
        input count_t last_excl
    );
        return (pos >= first) && (pos < last_excl);
    endfunction

    // Increment a position counter, returning to zero after 'last'.
    function automatic count_t next_count(
        input count_t value,
        input count_t last
    );
        return (value == last) ? '0 : value + count_t'(1);
    endfunction

endpackage : vga_timing_pkg

// File: rtl/vga_sync_to_count.sv
// ----------------------------------------------------------------------------
// vga_sync_to_count
//
// Purpose : First pipeline stage of the VGA back end. Registers the upstream
//           active-area flags and colour, detects the start of a frame from
//           the rising edge of the active-row flag and rebuilds the column/row
//           position of the sample currently held in the stage-1 registers.
//           Also owns the lock flag and the frame-start alignment check.
//
// Ports   :
//   i_Clk, i_Rst_L          pixel clock, asynchronous active-low reset
//   i_HSync, i_VSync        upstream active-column / active-row flags
//   i_Red, i_Grn, i_Blu     colour aligned with the flags
//   o_Act_H, o_Act_V        stage-1 copies of the flags (r1_HSync/r1_VSync)
//   o_Red, o_Grn, o_Blu     stage-1 copies of the colour
//   o_Col, o_Row            position of the stage-1 sample (r_Col/r_Row)
//   o_Frame_Start           high while the stage-1 sample is a frame start
//   o_Misaligned            result of the alignment check made at the most
//                           recent frame start (valid with o_Frame_Start)
//   o_Locked                high once a frame start has been seen
// ----------------------------------------------------------------------------
module vga_sync_to_count #(
    parameter int TOTAL_COLS  = vga_timing_pkg::TOTAL_COLS,
    parameter int TOTAL_ROWS  = vga_timing_pkg::TOTAL_ROWS,
    parameter int VIDEO_WIDTH = vga_timing_pkg::VIDEO_WIDTH
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst_L,
    input  logic                   i_HSync,
    input  logic                   i_VSync,
    input  logic [VIDEO_WIDTH-1:0] i_Red,
    input  logic [VIDEO_WIDTH-1:0] i_Grn,
    input  logic [VIDEO_WIDTH-1:0] i_Blu,
    output logic                   o_Act_H,
    output logic                   o_Act_V,
    output logic [VIDEO_WIDTH-1:0] o_Red,
    output logic [VIDEO_WIDTH-1:0] o_Grn,
    output logic [VIDEO_WIDTH-1:0] o_Blu,
    output vga_timing_pkg::count_t o_Col,
    output vga_timing_pkg::count_t o_Row,
    output logic                   o_Frame_Start,
    output logic                   o_Misaligned,
    output logic                   o_Locked
);

    import vga_timing_pkg::*;

    localparam count_t COL_LAST = count_t'(TOTAL_COLS - 1);
    localparam count_t ROW_LAST = count_t'(TOTAL_ROWS - 1);

    // Stage-1 registers
    logic                   r1_Valid;
    logic                   r1_HSync;
    logic                   r1_VSync;
    logic [VIDEO_WIDTH-1:0] r1_Red;
    logic [VIDEO_WIDTH-1:0] r1_Grn;
    logic [VIDEO_WIDTH-1:0] r1_Blu;

    // Position of the stage-1 sample plus lock/alignment state
    count_t r_Col;
    count_t r_Row;
    logic   r_Locked;
    logic   r_Frame_Start;
    logic   r_Misaligned;

    logic w_Frame_Start;
    logic w_At_Last;

    // r1_Valid blocks a false frame start on the first clock after reset:
    // reset clears r1_VSync, so an upstream that is mid-frame (i_VSync=1)
    // would otherwise look like a rising edge and lock onto a partial frame.
    assign w_Frame_Start = i_VSync & ~r1_VSync & r1_Valid;

    // A frame start is only expected right after the last pixel of a frame.
    assign w_At_Last = (r_Col == COL_LAST) && (r_Row == ROW_LAST);

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r1_Valid      <= 1'b0;
            r1_HSync      <= 1'b0;
            r1_VSync      <= 1'b0;
            r1_Red        <= '0;
            r1_Grn        <= '0;
            r1_Blu        <= '0;
            r_Col         <= '0;
            r_Row         <= '0;
            r_Locked      <= 1'b0;
            r_Frame_Start <= 1'b0;
            r_Misaligned  <= 1'b0;
        end else begin
            r1_Valid      <= 1'b1;
            r1_HSync      <= i_HSync;
            r1_VSync      <= i_VSync;
            r1_Red        <= i_Red;
            r1_Grn        <= i_Grn;
            r1_Blu        <= i_Blu;
            r_Frame_Start <= w_Frame_Start;

            if (w_Frame_Start) begin
                // Always snap to the new origin; only a frame start that
                // arrives while already locked can be judged misaligned.
                r_Col        <= '0;
                r_Row        <= '0;
                r_Locked     <= 1'b1;
                r_Misaligned <= r_Locked & ~w_At_Last;
            end else begin
                r_Col <= next_count(r_Col, COL_LAST);
                if (r_Col == COL_LAST) begin
                    r_Row <= next_count(r_Row, ROW_LAST);
                end
            end
        end
    end

    assign o_Act_H       = r1_HSync;
    assign o_Act_V       = r1_VSync;
    assign o_Red         = r1_Red;
    assign o_Grn         = r1_Grn;
    assign o_Blu         = r1_Blu;
    assign o_Col         = r_Col;
    assign o_Row         = r_Row;
    assign o_Frame_Start = r_Frame_Start;
    assign o_Misaligned  = r_Misaligned;
    assign o_Locked      = r_Locked;

endmodule : vga_sync_to_count

// File: rtl/vga_sync_porch.sv
// ----------------------------------------------------------------------------
// vga_sync_porch
//
// Purpose : VGA back end placed directly after the sync/count generator.
//           Rebuilds the pixel position from the upstream active-area flags
//           (vga_sync_to_count), then decodes real active-low HSync/VSync
//           pulses with front and back porch and blanks the colour. All
//           outputs are registered and describe the input sample taken two
//           clocks earlier, so sync and video leave the block aligned.
//
// Ports   :
//   i_Clk                   pixel clock (25 MHz for 640x480)
//   i_Rst_L                 asynchronous active-low reset
//   i_HSync, i_VSync        upstream active-column / active-row flags
//   i_Red, i_Grn, i_Blu     pixel colour aligned with the flags
//   o_HSync, o_VSync        VGA sync pulses, active-low
//   o_Red, o_Grn, o_Blu     colour, forced to 0 outside the visible area
//   o_Locked                high once the first frame start has been seen
//   o_Sync_Err              one-cycle pulse when a frame start arrives at
//                           an unexpected position while locked
// ----------------------------------------------------------------------------
module vga_sync_porch #(
    parameter int TOTAL_COLS    = vga_timing_pkg::TOTAL_COLS,
    parameter int TOTAL_ROWS    = vga_timing_pkg::TOTAL_ROWS,
    parameter int ACTIVE_COLS   = vga_timing_pkg::ACTIVE_COLS,
    parameter int ACTIVE_ROWS   = vga_timing_pkg::ACTIVE_ROWS,
    parameter int H_FRONT_PORCH = vga_timing_pkg::H_FRONT_PORCH,
    parameter int H_SYNC_WIDTH  = vga_timing_pkg::H_SYNC_WIDTH,
    parameter int V_FRONT_PORCH = vga_timing_pkg::V_FRONT_PORCH,
    parameter int V_SYNC_WIDTH  = vga_timing_pkg::V_SYNC_WIDTH,
    parameter int VIDEO_WIDTH   = vga_timing_pkg::VIDEO_WIDTH
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst_L,
    input  logic                   i_HSync,
    input  logic                   i_VSync,
    input  logic [VIDEO_WIDTH-1:0] i_Red,
    input  logic [VIDEO_WIDTH-1:0] i_Grn,
    input  logic [VIDEO_WIDTH-1:0] i_Blu,
    output logic                   o_HSync,
    output logic                   o_VSync,
    output logic [VIDEO_WIDTH-1:0] o_Red,
    output logic [VIDEO_WIDTH-1:0] o_Grn,
    output logic [VIDEO_WIDTH-1:0] o_Blu,
    output logic                   o_Locked,
    output logic                   o_Sync_Err
);

    import vga_timing_pkg::*;

    // Sync windows as half-open counter ranges, fixed at elaboration.
    // TOTAL_COLS and TOTAL_ROWS must not exceed COUNT_LIMIT (1024).
    localparam count_t HS_FIRST = count_t'(ACTIVE_COLS + H_FRONT_PORCH);
    localparam count_t HS_END   = count_t'(ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_WIDTH);
    localparam count_t VS_FIRST = count_t'(ACTIVE_ROWS + V_FRONT_PORCH);
    localparam count_t VS_END   = count_t'(ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_WIDTH);

    localparam int NUM_CHAN = 3;

    // Stage-1 view from the counter block
    logic                   w_Act_H;
    logic                   w_Act_V;
    logic [VIDEO_WIDTH-1:0] w_Red;
    logic [VIDEO_WIDTH-1:0] w_Grn;
    logic [VIDEO_WIDTH-1:0] w_Blu;
    count_t                 w_Col;
    count_t                 w_Row;
    logic                   w_Frame_Start;
    logic                   w_Misaligned;
    logic                   w_Locked;

    logic [VIDEO_WIDTH-1:0] w_S1_Rgb [NUM_CHAN];
    logic                   w_Video_On;

    vga_sync_to_count #(
        .TOTAL_COLS  (TOTAL_COLS),
        .TOTAL_ROWS  (TOTAL_ROWS),
        .VIDEO_WIDTH (VIDEO_WIDTH)
    ) u_sync_to_count (
        .i_Clk         (i_Clk),
        .i_Rst_L       (i_Rst_L),
        .i_HSync       (i_HSync),
        .i_VSync       (i_VSync),
        .i_Red         (i_Red),
        .i_Grn         (i_Grn),
        .i_Blu         (i_Blu),
        .o_Act_H       (w_Act_H),
        .o_Act_V       (w_Act_V),
        .o_Red         (w_Red),
        .o_Grn         (w_Grn),
        .o_Blu         (w_Blu),
        .o_Col         (w_Col),
        .o_Row         (w_Row),
        .o_Frame_Start (w_Frame_Start),
        .o_Misaligned  (w_Misaligned),
        .o_Locked      (w_Locked)
    );

    assign w_S1_Rgb[0] = w_Red;
    assign w_S1_Rgb[1] = w_Grn;
    assign w_S1_Rgb[2] = w_Blu;

    // Blanking follows the flags that travelled with the colour rather than
    // the rebuilt counters, so a glitchy upstream can never leak colour
    // into its own blanking interval.
    assign w_Video_On = w_Locked & w_Act_H & w_Act_V;

    // Stage 2: sync decode. VSync is a pure function of the row, so it
    // changes at the start of a line without extra alignment to HSync.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            o_HSync    <= 1'b1;
            o_VSync    <= 1'b1;
            o_Locked   <= 1'b0;
            o_Sync_Err <= 1'b0;
        end else begin
            o_HSync    <= ~(w_Locked & in_window(w_Col, HS_FIRST, HS_END));
            o_VSync    <= ~(w_Locked & in_window(w_Row, VS_FIRST, VS_END));
            // Lock is delayed with the video so it flags the same sample.
            o_Locked   <= w_Locked;
            o_Sync_Err <= w_Frame_Start & w_Misaligned;
        end
    end

    // Stage 2: one blanking register per colour channel.
    for (genvar gi = 0; gi < NUM_CHAN; gi++) begin : g_chan
        logic [VIDEO_WIDTH-1:0] r2_chan;

        always_ff @(posedge i_Clk or negedge i_Rst_L) begin
            if (!i_Rst_L) begin
                r2_chan <= '0;
            end else begin
                r2_chan <= w_Video_On ? w_S1_Rgb[gi] : '0;
            end
        end
    end

    assign o_Red = g_chan[0].r2_chan;
    assign o_Grn = g_chan[1].r2_chan;
    assign o_Blu = g_chan[2].r2_chan;

endmodule : vga_sync_porch
